// File: rtl/gray2bin_seq_pkg.sv
// rtl/gray2bin_seq_pkg.sv - shared state encoding and default width for the Gray decoder
package gray2bin_seq_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gray2bin_seq_step.sv
// rtl/gray2bin_seq_step.sv - flags whether two Gray words differ in exactly one bit
module gray_step_check
    import gray2bin_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] prev,
    output logic             one_bit
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] diff;

    // Clearing the lowest set bit leaves zero only for a power of two.
    assign diff    = cur ^ prev;
    assign one_bit = (diff != '0) && ((diff & (diff - ONE)) == '0);

endmodule

// File: rtl/gray2bin_seq.sv
// rtl/gray2bin_seq.sv - bit-serial Gray-to-binary decoder with single-step checking
module gray2bin_seq
    import gray2bin_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] g_in,
    output logic [WIDTH-1:0] b_out,
    output logic             busy,
    output logic             done,
    output logic             step_err
);

    localparam int               IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_g;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic [WIDTH-1:0] g_prev;
    logic [IDX_W-1:0] idx;
    logic             run_bit;
    logic             cur_bit;
    logic             first_flag;
    logic             err_pend;
    logic             capture;
    logic             one_bit;

    gray_step_check #(.WIDTH(WIDTH)) u_step (
        .cur     (g_in),
        .prev    (g_prev),
        .one_bit (one_bit)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                capture = start;
                if (start) state_nxt = ST_CONV;
            end
            ST_CONV: begin
                busy = 1'b1;
                if (idx == '0) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                capture   = start;
                state_nxt = start ? ST_CONV : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_bit       = run_bit ^ shift_g[idx];
        work_nxt      = work;
        work_nxt[idx] = cur_bit;
    end

    // The step verdict is formed at capture and held until the word completes.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            shift_g    <= '0;
            work       <= '0;
            g_prev     <= '0;
            idx        <= '0;
            run_bit    <= 1'b0;
            err_pend   <= 1'b0;
            first_flag <= 1'b1;
            b_out      <= '0;
            step_err   <= 1'b0;
        end else if (capture) begin
            shift_g    <= g_in;
            work       <= '0;
            idx        <= IDX_TOP;
            run_bit    <= 1'b0;
            err_pend   <= !first_flag && !one_bit;
            g_prev     <= g_in;
            first_flag <= 1'b0;
        end else if (state == ST_CONV) begin
            work    <= work_nxt;
            run_bit <= cur_bit;
            idx     <= idx - IDX_ONE;
            if (idx == '0) begin
                b_out    <= work_nxt;
                step_err <= err_pend;
            end
        end
    end

endmodule

// File: tb/tb_gray2bin_seq.sv
// tb/tb_gray2bin_seq.sv - self-checking bench for gray2bin_seq
module tb_gray2bin_seq;

    localparam int W = 4;

    logic         Clock = 1'b0;
    logic         Resetn;
    logic         start;
    logic [W-1:0] g_in;
    logic [W-1:0] b_out;
    logic         busy;
    logic         done;
    logic         step_err;

    int n_tests = 0;
    int n_fail  = 0;

    gray2bin_seq #(.WIDTH(W)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .start    (start),
        .g_in     (g_in),
        .b_out    (b_out),
        .busy     (busy),
        .done     (done),
        .step_err (step_err)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b ^= g >> s;
        return b;
    endfunction

    // Reference model: a word accepted at edge n completes at edge n+W;
    // the decoder may take a new word from edge n+W+1 onward.
    int           cyc = 0;
    bit           m_valid = 1'b0;
    bit           m_active = 1'b0;
    int           m_acc = 0;
    logic [W-1:0] m_pend_b;
    bit           m_pend_err;
    logic [W-1:0] m_prev;
    bit           m_have_prev = 1'b0;
    int           m_done_cnt = 0;
    logic [W-1:0] exp_b = '0;
    bit           exp_err = 1'b0;
    bit           exp_busy = 1'b0;
    bit           exp_done = 1'b0;

    always @(posedge Clock) begin
        cyc++;
        m_valid = 1'b1;
        if (!Resetn) begin
            m_active    = 1'b0;
            m_have_prev = 1'b0;
            exp_b       = '0;
            exp_err     = 1'b0;
            exp_busy    = 1'b0;
            exp_done    = 1'b0;
        end else begin
            exp_done = m_active && (cyc == m_acc + W);
            if (exp_done) begin
                exp_b   = m_pend_b;
                exp_err = m_pend_err;
                m_done_cnt++;
            end
            if (m_active && cyc > m_acc + W) m_active = 1'b0;
            if (start && !m_active) begin
                m_acc       = cyc;
                m_active    = 1'b1;
                m_pend_b    = g2b(g_in);
                m_pend_err  = m_have_prev && ($countones(g_in ^ m_prev) != 1);
                m_prev      = g_in;
                m_have_prev = 1'b1;
            end
            exp_busy = m_active && (cyc < m_acc + W);
        end
    end

    always @(negedge Clock) begin
        if (m_valid) begin
            check("b_out", b_out, exp_b);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (exp_done) check("step_err", step_err, exp_err);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            n++;
            if (done) break;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic run_word(input logic [W-1:0] g, input logic [W-1:0] eb, input bit ee,
                            input string name);
        int n;
        start = 1'b1;
        g_in  = g;
        @(negedge Clock);
        start = 1'b0;
        wait_done(n);
        check({name, "_latency"}, n, W);
        check({name, "_b"}, b_out, eb);
        check({name, "_err"}, step_err, ee);
    endtask

    initial begin
        int n;
        int dc0;
        Resetn = 1'b0;
        start  = 1'b1;
        g_in   = 4'b1111;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_b", b_out, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", step_err, 1'b0);
        Resetn = 1'b1;
        start  = 1'b0;
        @(negedge Clock);
        check("rst_nostart", busy, 1'b0);

        run_word(4'b0110, 4'b0100, 1'b0, "first");
        @(negedge Clock);
        run_word(4'b0111, 4'b0101, 1'b0, "step_ok");
        @(negedge Clock);
        run_word(4'b0100, 4'b0111, 1'b1, "two_bits");
        @(negedge Clock);
        run_word(4'b0100, 4'b0111, 1'b1, "repeat");
        @(negedge Clock);

        // Back-to-back: new start asserted while done is visible.
        run_word(4'b1100, 4'b1000, 1'b0, "b2b_a");
        start = 1'b1;
        g_in  = 4'b1000;
        @(negedge Clock);
        start = 1'b0;
        wait_done(n);
        check("b2b_spacing", n + 1, W + 1);
        check("b2b_b", b_out, 4'b1111);
        check("b2b_err", step_err, 1'b0);
        @(negedge Clock);

        // Inputs churning during conversion must not disturb it.
        start = 1'b1;
        g_in  = 4'b1001;
        @(negedge Clock);
        g_in = 4'b0101;
        @(negedge Clock);
        g_in = 4'b1111;
        @(negedge Clock);
        g_in = 4'b0000;
        @(negedge Clock);
        start = 1'b0;
        wait_done(n);
        check("churn_spacing", n + 4, W + 1);
        check("churn_b", b_out, 4'b1110);
        check("churn_err", step_err, 1'b0);
        @(negedge Clock);

        // Abort at the second conversion edge.
        start = 1'b1;
        g_in  = 4'b1011;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        check("abort_b", b_out, 4'b0000);
        check("abort_busy", busy, 1'b0);
        repeat (6) @(negedge Clock);
        run_word(4'b0101, 4'b0110, 1'b0, "after_abort");
        @(negedge Clock);

        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        dc0 = m_done_cnt;
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] gi;
            gi = W'(i ^ (i >> 1));
            run_word(gi, W'(i), 1'b0, "sweep");
            @(negedge Clock);
        end
        check("sweep_done_count", m_done_cnt - dc0, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray2bin_seq.md
Name: gray2bin_seq

Overview:
Bit-serial Gray-to-binary decoder. It is the inverse of the team's combinational binary-to-Gray encoder.
- Captures a WIDTH-bit Gray word on a start strobe and resolves one binary bit per clock, MSB first, using b[i] = b[i+1] ^ g[i].
- Presents the full binary word with a one-cycle done pulse.
- Flags any accepted word that is not a legal single-bit Gray step from the previously accepted word.
- Sits downstream of Gray-coded counters and encoders in the lab datapath.

Parameters:
WIDTH, 4, width of the Gray input and binary output in bits (min 2)

Ports:
Clock    input   1      rising-edge system clock
Resetn   input   1      synchronous reset, active-low
start    input   1      request to capture g_in; sampled each rising edge
g_in     input   WIDTH  Gray-coded word to decode
b_out    output  WIDTH  decoded binary word; holds last result until next completion
busy     output  1      high while a conversion is in progress (CONV state)
done     output  1      one-cycle pulse when b_out/step_err are updated
step_err output  1      valid with done: accepted word is not a single-bit step from the previous accepted word

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock and Resetn as named above.
- Reset: Resetn sampled low at an edge forces the following, overriding all other inputs:
  - state=IDLE; b_out=0, busy=0, done=0, step_err=0;
  - working register, bit index and running bit cleared;
  - previous-word history cleared and first_flag set.
- FSM states: IDLE, CONV, DONE (2-bit registered encoding).
- IDLE: busy=0. start=1 at edge E0 captures g_in into shift_g, sets idx=WIDTH-1 and run_bit=0, then moves to CONV.
- CONV: busy=1. At each edge:
  - work[idx] = run_bit ^ shift_g[idx]; run_bit takes that value; idx decrements.
  - The edge that writes bit 0 (E_WIDTH) loads b_out with the full word, registers step_err, sets done=1 and moves to DONE.
  - start is ignored in CONV and g_in changes are ignored; the captured word only is used.
- DONE (one cycle): done=1, busy=0.
  - start=1 → capture g_in, go to CONV (back-to-back; throughput one word per WIDTH+1 cycles).
  - Otherwise go to IDLE.
  - done drops at the next edge unless another completion occurs.
- Latency: start sampled at E0 → done high in the cycle after E_WIDTH. For WIDTH=4, done is visible 4 clocks after the start edge.
- step_err:
  - Computed at capture as popcount(g_captured ^ g_prev) != 1, and presented with done.
  - First word after reset: step_err=0 (first_flag), then first_flag is cleared.
  - A repeated identical word is an error (popcount 0).
  - g_prev updates to the captured word at every capture.
- done, b_out and step_err are fully registered; no combinational path from inputs to outputs.
- Reset mid-conversion: the conversion is aborted with no done pulse, b_out=0, and history is cleared.
- Start and Resetn=0 at the same edge: reset wins.

Decomposition:
- Shared include/package: state encodings (ST_IDLE=2'd0, ST_CONV=2'd1, ST_DONE=2'd2) and the default WIDTH.
- One sub-module: gray_step_check (combinational, WIDTH-parameterised). Inputs cur and prev; output one_bit, high when exactly one bit of cur ^ prev is set. Instantiated once at the capture path.
- FSM, shift register and bit index stay in gray2bin_seq.

Test Plan:
1. Resetn=0 for 2 edges with start=1, g_in=4'b1111 → b_out=0, busy=0, done=0, step_err=0; no conversion starts.
2. After reset, start pulse with g_in=4'b0110 → busy high 4 cycles, then done=1 for 1 cycle with b_out=4'b0100 and step_err=0 (first word).
3. Next start, g_in=4'b0111 → b_out=4'b0101, step_err=0. Then g_in=4'b0100 → b_out=4'b0111, step_err=1 (two bits changed). Then g_in=4'b0100 again → step_err=1 (repeat).
4. start held high through DONE with g_in=4'b1000 → next conversion begins without an IDLE cycle; b_out=4'b1111 exactly WIDTH+1 cycles after the previous done.
5. start=1 and g_in toggled during CONV → no effect on the result or the cycle count. Resetn=0 at the second CONV edge → no done, b_out=0; the next word reports step_err=0.
6. Sweep the Gray codes of 0..15 in order with single start pulses → b_out=0..15 respectively, step_err=0 for all; done count=16.
